// File: rtl/bet_pkg.sv
// Shared opcodes, FSM states and bet-table entry layout for the
// roulette bet intake controller.
package bet_pkg;

    localparam logic [5:0] OPC_NONE = 6'b111111;
    localparam logic [5:0] OPC_SPIN = 6'b111110;

    localparam int BET_W   = 8;
    localparam int OPC_W   = 6;
    localparam int AMT_W   = 2;
    localparam int AMT_LSB = OPC_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LOCKED = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    typedef struct packed {
        logic [AMT_W-1:0] amount;
        logic [OPC_W-1:0] opcode;
    } bet_entry_t;

endpackage

// File: rtl/bet_intake_controller_holdoff_timer.sv
// Loadable down-counter that keeps busy high for HOLDOFF_CYCLES cycles
// after load and pulses expire in the last busy cycle.
module holdoff_timer #(
    parameter int HOLDOFF_CYCLES = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic busy,
    output logic expire
);

    localparam int CNT_W = $clog2(HOLDOFF_CYCLES);

    logic [CNT_W-1:0] count;
    logic             active;

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= CNT_W'(HOLDOFF_CYCLES - 1);
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign busy   = active;
    assign expire = active && (count == '0);

endmodule

// File: rtl/bet_intake_controller.sv
// Bet capture sequencer for one roulette round: accepts keyboard bets with
// chip colour, stores them in a flat table, issues a spin, clears on payout.
//
// state  | meaning
// IDLE   | accepting bets or a spin request
// HOLD   | hold-off after an accepted bet, keys rejected
// LOCKED | spin issued, table frozen until spin_done
// CLEAR  | one-cycle wipe of table and bet_count
module bet_intake_controller
    import bet_pkg::*;
#(
    parameter int MAX_BETS       = 12,
    parameter int HOLDOFF_CYCLES = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [5:0] key_opcode,
    input  logic [2:0] chip_color,
    input  logic       spin_done,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_bet,
    output logic [3:0] bet_count,
    output logic       bet_received,
    output logic       spin_req,
    output logic       locked,
    output logic       reject
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BETS);

    state_t           state, state_next;
    logic [BET_W-1:0] bet_table [MAX_BETS];
    logic [BET_W-1:0] rd_mux;
    bet_entry_t       new_entry;
    logic             wr_en, load, clear, reject_d, spin_d;
    logic             hold_busy, hold_expire;

    holdoff_timer #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .busy  (hold_busy),
        .expire(hold_expire)
    );

    assign new_entry = '{amount: chip_color[1:0], opcode: key_opcode};

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        reject_d   = 1'b0;
        spin_d     = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    if (key_opcode == OPC_SPIN) begin
                        if (bet_count != 4'd0) begin
                            spin_d     = 1'b1;
                            state_next = LOCKED;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (key_opcode != OPC_NONE) begin
                        if (chip_color[2] && (bet_count < MAX_CNT)) begin
                            wr_en      = 1'b1;
                            load       = 1'b1;
                            state_next = HOLD;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                reject_d = key_valid;
                if (hold_expire) state_next = IDLE;
            end
            LOCKED: begin
                reject_d = key_valid;
                if (spin_done) state_next = CLEAR;
            end
            CLEAR: begin
                reject_d   = key_valid;
                clear      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < MAX_BETS; i++) begin
            if (rd_idx == 4'(i)) rd_mux = bet_table[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bet_count <= 4'd0;
            rd_bet    <= '0;
            reject    <= 1'b0;
            spin_req  <= 1'b0;
            for (int i = 0; i < MAX_BETS; i++) bet_table[i] <= '0;
        end else begin
            state    <= state_next;
            reject   <= reject_d;
            spin_req <= spin_d;
            rd_bet   <= rd_mux;
            if (clear) begin
                bet_count <= 4'd0;
            end else if (wr_en) begin
                bet_count <= bet_count + 4'd1;
            end
            for (int i = 0; i < MAX_BETS; i++) begin
                if (clear) begin
                    bet_table[i] <= '0;
                end else if (wr_en && (bet_count == 4'(i))) begin
                    bet_table[i] <= new_entry;
                end
            end
        end
    end

    assign bet_received = hold_busy;
    assign locked       = (state == LOCKED) || (state == CLEAR);

endmodule

// File: tb/tb_bet_intake_controller.sv
// Directed self-checking bench for bet_intake_controller with a 4-cycle hold-off.
module tb_bet_intake_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [5:0] key_opcode = 6'h3F;
    logic [2:0] chip_color = 3'b000;
    logic       spin_done = 1'b0;
    logic [3:0] rd_idx = 4'd0;
    logic [7:0] rd_bet;
    logic [3:0] bet_count;
    logic       bet_received, spin_req, locked, reject;

    int n_tests = 0;
    int n_fail  = 0;

    bet_intake_controller #(
        .MAX_BETS(12),
        .HOLDOFF_CYCLES(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_opcode  (key_opcode),
        .chip_color  (chip_color),
        .spin_done   (spin_done),
        .rd_idx      (rd_idx),
        .rd_bet      (rd_bet),
        .bet_count   (bet_count),
        .bet_received(bet_received),
        .spin_req    (spin_req),
        .locked      (locked),
        .reject      (reject)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic press(input logic [5:0] op, input logic [2:0] color);
        key_valid  = 1'b1;
        key_opcode = op;
        chip_color = color;
        tick();
        key_valid  = 1'b0;
    endtask

    task automatic rd_check(input logic [3:0] idx, input logic [7:0] exp, input string tag);
        rd_idx = idx;
        tick();
        chk(tag, rd_bet, exp);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && bet_received; k++) tick();
        chk("hold_end", bet_received, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_count"}, bet_count, 0);
        chk({tag, "_recv"}, bet_received, 0);
        chk({tag, "_spin"}, spin_req, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_reject"}, reject, 0);
    endtask

    initial begin
        // reset state
        tick();
        do_reset();
        chk_quiet("rst");
        chk("rst_rdbet", rd_bet, 0);

        // single accepted bet, hold-off length, same-cycle read returns old value
        rd_idx = 4'd0;
        press(6'h05, 3'b110);
        chk("b1_count", bet_count, 1);
        chk("b1_recv", bet_received, 1);
        chk("b1_reject", reject, 0);
        chk("b1_rd_old", rd_bet, 8'h00);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("b1_recv_hold", bet_received, 1);
        end
        tick();
        chk("b1_recv_done", bet_received, 0);
        rd_check(4'd0, 8'h85, "b1_entry0");

        // key during hold-off rejected, retry after hold-off accepted
        do_reset();
        press(6'h05, 3'b110);
        tick();
        press(6'h0A, 3'b111);
        chk("hold_reject", reject, 1);
        chk("hold_count", bet_count, 1);
        tick();
        chk("hold_reject_pulse", reject, 0);
        wait_idle();
        press(6'h0A, 3'b111);
        chk("retry_count", bet_count, 2);
        chk("retry_reject", reject, 0);
        rd_check(4'd1, 8'hCA, "retry_entry1");
        rd_check(4'd0, 8'h85, "retry_entry0");

        // no chip, no-bet opcode, spin with empty table
        do_reset();
        press(6'h03, 3'b010);
        chk("nochip_reject", reject, 1);
        chk("nochip_count", bet_count, 0);
        chk("nochip_recv", bet_received, 0);
        rd_check(4'd0, 8'h00, "nochip_entry0");
        press(6'h3F, 3'b110);
        chk_quiet("none");
        press(6'h3E, 3'b100);
        chk("spin0_reject", reject, 1);
        chk("spin0_spin", spin_req, 0);
        chk("spin0_locked", locked, 0);

        // fill the table, overflow, spin, lock, clear
        do_reset();
        for (int i = 0; i < 12; i++) begin
            press(6'(i), {1'b1, 2'(i)});
            wait_idle();
        end
        chk("full_count", bet_count, 12);
        press(6'h20, 3'b111);
        chk("full_reject", reject, 1);
        chk("full_count2", bet_count, 12);
        chk("full_recv", bet_received, 0);
        press(6'h3E, 3'b000);
        chk("spin_req", spin_req, 1);
        chk("spin_locked", locked, 1);
        chk("spin_reject", reject, 0);
        tick();
        chk("spin_req_pulse", spin_req, 0);
        press(6'h01, 3'b111);
        chk("locked_reject", reject, 1);
        chk("locked_count", bet_count, 12);
        rd_check(4'd5, 8'h45, "full_entry5");
        rd_check(4'd11, 8'hCB, "full_entry11");
        rd_check(4'd12, 8'h00, "rd_oob12");
        rd_check(4'd15, 8'h00, "rd_oob15");
        spin_done = 1'b1;
        tick();
        spin_done = 1'b0;
        chk("clear_locked", locked, 1);
        tick();
        chk("after_clear_locked", locked, 0);
        chk("after_clear_count", bet_count, 0);
        for (int i = 0; i < 12; i++) rd_check(4'(i), 8'h00, "cleared_entry");

        // spin_done outside LOCKED ignored
        press(6'h07, 3'b101);
        spin_done = 1'b1;
        tick();
        spin_done = 1'b0;
        chk("stray_done_count", bet_count, 1);
        chk("stray_done_locked", locked, 0);

        // reset during HOLD
        do_reset();
        press(6'h09, 3'b111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("rst_hold");
        press(6'h09, 3'b111);
        chk("rst_hold_accept", bet_count, 1);

        // reset during LOCKED
        wait_idle();
        press(6'h3E, 3'b000);
        chk("pre_rst_locked", locked, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_quiet("rst_lock");
        chk("rst_lock_rdbet", rd_bet, 0);
        tick();
        chk_quiet("rst_lock_next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
